// File: rtl/tbird_input_conditioner.sv
// Front end for the T-Bird tail-light sequencer: sync, debounce and decode sw0/sw1, and generate the step tick.
// Latency: a raw switch change reaches mode DEBOUNCE_CYCLES+3 clk edges later; step_tick first fires STEP_CYCLES after mode_change.
// Backpressure: none; all outputs are free-running registered levels or one-cycle strobes.
module tbird_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned STEP_CYCLES     = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw0,
    input  logic       sw1,
    output logic [1:0] mode,
    output logic       mode_change,
    output logic       step_tick,
    output logic       err
);

    localparam int unsigned DCNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned SCNT_W = $clog2(STEP_CYCLES);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(STEP_CYCLES - 1);

    // Bit 1 carries sw1 and bit 0 carries sw0, so deb_q is directly the mode pair.
    logic [1:0]             sync1_q, sync1_d;
    logic [1:0]             sync2_q, sync2_d;
    logic [1:0]             deb_q, deb_d;
    logic [1:0][DCNT_W-1:0] dcnt_q, dcnt_d;

    logic [1:0]             mode_q, mode_d;
    logic                   mode_change_q, mode_change_d;
    logic                   step_tick_q, step_tick_d;
    logic                   err_q, err_d;
    logic [SCNT_W-1:0]      scnt_q, scnt_d;

    always_comb begin
        sync1_d = {sw1, sw0};
        sync2_d = sync1_q;
    end

    always_comb begin
        deb_d  = deb_q;
        dcnt_d = dcnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                dcnt_d[i] = '0;
            end else if (dcnt_q[i] == DCNT_LAST) begin
                deb_d[i]  = sync2_q[i];
                dcnt_d[i] = '0;
            end else begin
                dcnt_d[i] = dcnt_q[i] + DCNT_W'(1);
            end
        end
    end

    // A commit restarts the step counter so every new pattern starts phase-aligned.
    always_comb begin
        mode_d        = mode_q;
        mode_change_d = 1'b0;
        step_tick_d   = 1'b0;
        scnt_d        = scnt_q;
        if (deb_q != mode_q) begin
            mode_d        = deb_q;
            mode_change_d = 1'b1;
            scnt_d        = '0;
        end else if (mode_q == 2'b00) begin
            scnt_d = '0;
        end else if (scnt_q == SCNT_LAST) begin
            scnt_d      = '0;
            step_tick_d = 1'b1;
        end else begin
            scnt_d = scnt_q + SCNT_W'(1);
        end
        err_d = (mode_d == 2'b11);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            deb_q         <= '0;
            dcnt_q        <= '0;
            mode_q        <= 2'b00;
            mode_change_q <= 1'b0;
            step_tick_q   <= 1'b0;
            err_q         <= 1'b0;
            scnt_q        <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            deb_q         <= deb_d;
            dcnt_q        <= dcnt_d;
            mode_q        <= mode_d;
            mode_change_q <= mode_change_d;
            step_tick_q   <= step_tick_d;
            err_q         <= err_d;
            scnt_q        <= scnt_d;
        end
    end

    assign mode        = mode_q;
    assign mode_change = mode_change_q;
    assign step_tick   = step_tick_q;
    assign err         = err_q;

endmodule

// File: tb/tb_tbird_input_conditioner.sv
// Bench for tbird_input_conditioner: directed scenarios with literal expectations plus random switch activity
// checked every cycle against a window/phase model of the conditioner.
module tb_tbird_input_conditioner;

    localparam int D = 4;
    localparam int S = 8;

    logic       clk, rst, sw0, sw1;
    logic [1:0] mode;
    logic       mode_change, step_tick, err;

    int vectors     = 0;
    int miscompares = 0;

    tbird_input_conditioner #(.DEBOUNCE_CYCLES(D), .STEP_CYCLES(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .sw0        (sw0),
        .sw1        (sw1),
        .mode       (mode),
        .mode_change(mode_change),
        .step_tick  (step_tick),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: two-sample delay line, a sliding window of the last D synchronized samples,
    // and the number of edges elapsed since the last mode commit.
    bit       pipe [2][2];
    bit       win  [2][D];
    int       wlen [2];
    bit       deb  [2];
    bit [1:0] m_mode;
    bit       m_chg, m_tick, m_err;
    int       since;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            pipe[i][0] = 1'b0;
            pipe[i][1] = 1'b0;
            deb[i]     = 1'b0;
            wlen[i]    = 0;
        end
        m_mode = 2'b00;
        m_chg  = 1'b0;
        m_tick = 1'b0;
        m_err  = 1'b0;
        since  = 0;
    endtask

    task automatic model_edge(input bit r0, input bit r1);
        bit [1:0] p;
        bit       raw [2];
        bit       s2;
        bit       all_diff;
        raw[0] = r0;
        raw[1] = r1;
        p = {deb[1], deb[0]};
        if (p != m_mode) begin
            m_mode = p;
            m_chg  = 1'b1;
            m_tick = 1'b0;
            since  = 0;
        end else begin
            m_chg  = 1'b0;
            since  = since + 1;
            m_tick = (m_mode != 2'b00) && (since % S == 0);
        end
        m_err = (m_mode == 2'b11);
        for (int i = 0; i < 2; i++) begin
            s2         = pipe[i][1];
            pipe[i][1] = pipe[i][0];
            pipe[i][0] = raw[i];
            for (int j = D - 1; j > 0; j--) win[i][j] = win[i][j-1];
            win[i][0] = s2;
            if (wlen[i] < D) wlen[i] = wlen[i] + 1;
            all_diff = (wlen[i] == D);
            for (int j = 0; j < D; j++) if (win[i][j] == deb[i]) all_diff = 1'b0;
            if (all_diff) deb[i] = ~deb[i];
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_edge(sw0, sw1);
        end
    end

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            check("model_mode",  mode,        m_mode);
            check("model_chg",   mode_change, m_chg);
            check("model_tick",  step_tick,   m_tick);
            check("model_err",   err,         m_err);
        end
    end

    task automatic edges(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_mode"}, mode,        2'b00);
        check({name, "_chg"},  mode_change, 1'b0);
        check({name, "_tick"}, step_tick,   1'b0);
        check({name, "_err"},  err,         1'b0);
    endtask

    initial begin
        rst = 1'b0;
        sw0 = 1'b0;
        sw1 = 1'b0;
        #2 rst = 1'b1;
        edges(2);
        rst = 1'b0;
        edges(3);
        check_all_zero("reset");

        // IDLE -> RIGHT: commit after edge 7, ticks after edges 15, 23, 31.
        sw0 = 1'b1;
        edges(6);  check("right_e6_mode", mode, 2'b00);
        edges(1);  check("right_e7_mode", mode, 2'b01);
                   check("right_e7_chg",  mode_change, 1'b1);
                   check("right_e7_err",  err, 1'b0);
        edges(1);  check("right_e8_chg",  mode_change, 1'b0);
        edges(6);  check("right_e14_tick", step_tick, 1'b0);
        edges(1);  check("right_e15_tick", step_tick, 1'b1);
        edges(1);  check("right_e16_tick", step_tick, 1'b0);
        edges(7);  check("right_e23_tick", step_tick, 1'b1);
        edges(8);  check("right_e31_tick", step_tick, 1'b1);

        sw0 = 1'b0;
        edges(7);  check("idle_e7_mode", mode, 2'b00);
        edges(10);

        // Short sw1 excursion must be filtered out entirely.
        sw1 = 1'b1;
        edges(3);
        sw1 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            edges(1);
            check("glitch_mode", mode, 2'b00);
            check("glitch_chg",  mode_change, 1'b0);
            check("glitch_tick", step_tick, 1'b0);
        end

        // Both switches: ERROR mode ticks, then back to IDLE with ticks stopped.
        sw0 = 1'b1;
        sw1 = 1'b1;
        edges(7);  check("error_e7_mode", mode, 2'b11);
                   check("error_e7_err",  err, 1'b1);
                   check("error_e7_chg",  mode_change, 1'b1);
        edges(8);  check("error_e15_tick", step_tick, 1'b1);
        edges(8);  check("error_e23_tick", step_tick, 1'b1);
        sw0 = 1'b0;
        sw1 = 1'b0;
        edges(7);  check("error_off_mode", mode, 2'b00);
                   check("error_off_err",  err, 1'b0);
        for (int k = 0; k < 20; k++) begin
            edges(1);
            check("idle_no_tick", step_tick, 1'b0);
        end

        // RIGHT then simultaneous flip to LEFT mid-period: one direct commit, phase restarts.
        sw0 = 1'b1;
        edges(7);  check("r2l_right_mode", mode, 2'b01);
        edges(4);
        sw0 = 1'b0;
        sw1 = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            edges(1);
            if (k < 7) begin
                check("r2l_hold_mode", mode, 2'b01);
                check("r2l_hold_chg",  mode_change, 1'b0);
            end else begin
                check("r2l_e7_mode", mode, 2'b10);
                check("r2l_e7_chg",  mode_change, 1'b1);
            end
        end
        edges(1);  check("r2l_e8_chg",  mode_change, 1'b0);
        edges(4);  check("r2l_e12_tick", step_tick, 1'b0);
        edges(3);  check("r2l_e15_tick", step_tick, 1'b1);

        // Reset pulse during LEFT with the step counter at 5; switches stay held.
        edges(5);
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        edges(1);
        rst = 1'b0;
        edges(6);  check("rel_e6_mode", mode, 2'b00);
        edges(1);  check("rel_e7_mode", mode, 2'b10);
                   check("rel_e7_chg",  mode_change, 1'b1);
        edges(7);  check("rel_e14_tick", step_tick, 1'b0);
        edges(1);  check("rel_e15_tick", step_tick, 1'b1);

        // Random switch activity with occasional reset pulses; the model checks every cycle.
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0: sw0 = ~sw0;
                1: sw1 = ~sw1;
                2: begin sw0 = ~sw0; sw1 = ~sw1; end
                default: begin
                    sw0 = 1'($urandom_range(0, 1));
                    sw1 = 1'($urandom_range(0, 1));
                end
            endcase
            edges($urandom_range(1, 14));
            if ($urandom_range(0, 40) == 0) begin
                rst = 1'b1;
                edges(1);
                rst = 1'b0;
            end
        end
        edges(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
